// File: rtl/store_fetch_pkg.sv
// Shared store->fetch types: packet layout, default queue depth, count-width helper.
// Combinational definitions only; no latency or backpressure of its own.
package store_fetch_pkg;

  localparam int STF_QUEUE_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [1:0]  kind;
    logic [29:0] target;
  } StoreToFetchPacket;

  localparam int STF_PACKET_W = $bits(StoreToFetchPacket);

  function automatic int stf_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [stf_count_width(STF_QUEUE_DEPTH_DEFAULT)-1:0] store_to_fetch_count_t;

endpackage

// File: rtl/store_to_fetch_queue_if.sv
// Store->fetch queue bundle: producer send handshake, consumer recv handshake, flush and status.
// Slave is the queue; master is the store/fetch side driving it.
interface store_to_fetch_queue_if
  import store_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = STF_PACKET_W,
  parameter int COUNT_W    = stf_count_width(STF_QUEUE_DEPTH_DEFAULT)
);
  logic                  send_valid;
  logic                  send_ready;
  logic [DATA_WIDTH-1:0] send_data;
  logic                  recv_valid;
  logic                  recv_ready;
  logic [DATA_WIDTH-1:0] recv_data;
  logic                  flush;
  logic [COUNT_W-1:0]    count;
  logic                  almost_full;
  logic                  proto_err;

  modport slave (
    input  send_valid, send_data, recv_ready, flush,
    output send_ready, recv_valid, recv_data, count, almost_full, proto_err
  );

  modport master (
    output send_valid, send_data, recv_ready, flush,
    input  send_ready, recv_valid, recv_data, count, almost_full, proto_err
  );
endinterface

// File: rtl/stf_queue_storage.sv
// Unreset register file: one synchronous write port, one asynchronous read port.
// No flow control here; the enclosing queue gates the write enable.
module stf_queue_storage #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [PW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/store_to_fetch_queue.sv
// Store->fetch packet FIFO; push visible on recv one cycle later, one push + one pop per cycle.
// send_ready drops only when full (no same-cycle pop lookahead); flush wins over push/pop.
module store_to_fetch_queue
  import store_fetch_pkg::*;
#(
  parameter int DEPTH        = STF_QUEUE_DEPTH_DEFAULT,
  parameter int DATA_WIDTH   = STF_PACKET_W,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter bit STRICT       = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  store_to_fetch_queue_if.slave  q_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = stf_count_width(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          send_ready, recv_valid, push, pop, violation;

  assign send_ready = !reset_i && (count_q != CW'(DEPTH));
  assign recv_valid = !reset_i && (count_q != '0);
  assign push       = q_if.send_valid && send_ready;
  assign pop        = recv_valid && q_if.recv_ready;
  assign violation  = STRICT && !reset_i &&
                      ((q_if.send_valid && !send_ready) || (q_if.recv_ready && !recv_valid));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q || violation;
    if (q_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // A push coinciding with flush is dropped, so its write is suppressed as well.
  stf_queue_storage #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_storage (
    .clk_i   (clk_i),
    .we_i    (push && !q_if.flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (q_if.send_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (q_if.recv_data)
  );

  assign q_if.send_ready  = send_ready;
  assign q_if.recv_valid  = recv_valid;
  assign q_if.count       = count_q;
  assign q_if.almost_full = count_q >= CW'(AFULL_THRESH);
  assign q_if.proto_err   = err_q;

endmodule

// File: doc/store_to_fetch_queue.md
# store_to_fetch_queue

Parametrised, multi-entry successor to the single-slot store-to-fetch bus: a synchronous FIFO carrying StoreToFetchPacket payloads from the store stage back to the fetch stage. It uses valid/ready handshakes on both sides, so back-to-back packets no longer stall the store stage. It adds flush (pipeline redirect), occupancy and almost-full reporting, and a sticky protocol-error flag that replaces the single-slot bus's simulation-only assertions.

## Interface
- DEPTH, 4: entry count; power of two, ≥ 2.
- DATA_WIDTH, $bits(StoreToFetchPacket): payload width.
- AFULL_THRESH, DEPTH-1: almost_full asserts when count ≥ this value.
- STRICT, 1: 1 = producer must not raise send_valid while send_ready is low (error flagged); 0 = holding valid while not ready is a legal stall.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- send_valid  in  1  producer offers send_data.
- send_ready  out  1  queue can accept an entry this cycle.
- send_data  in  DATA_WIDTH  payload.
- recv_valid  out  1  head entry is available.
- recv_ready  in  1  consumer takes the head entry.
- recv_data  out  DATA_WIDTH  head entry payload.
- flush  in  1  discard all contents.
- count  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  count ≥ AFULL_THRESH.
- proto_err  out  1  sticky protocol-violation flag.

## Operation
- push = send_valid & send_ready; pop = recv_valid & recv_ready.
- send_ready = !reset & (count != DEPTH). It does not look ahead at a same-cycle pop, so a full queue never accepts an entry.
- recv_valid = !reset & (count != 0); recv_data = mem[rd_ptr]. recv_data is don't-care when recv_valid is low; the bench must not check it then.
- Storage: DEPTH × DATA_WIDTH register array. wr_ptr and rd_ptr are each $clog2(DEPTH) bits and wrap modulo DEPTH by natural overflow.
- Push: mem[wr_ptr] ← send_data, wr_ptr + 1. Pop: rd_ptr + 1.
- Count update: push only → count + 1; pop only → count − 1; push and pop together → count unchanged.
- Simultaneous push and pop is legal at any occupancy from 1 to DEPTH−1. When count == 0 only a push can occur; the entry becomes visible next cycle (no fall-through).
- Flush has priority over push and pop:
  - next cycle: count, wr_ptr and rd_ptr all = 0;
  - a push in the flush cycle is discarded;
  - a pop in the flush cycle counts as consumed by the consumer.
- proto_err sets when either holds:
  - STRICT == 1 and send_valid & !send_ready & !reset;
  - recv_ready & !recv_valid & !reset & STRICT == 1.
- proto_err stays set until reset; flush does not clear it. Violating requests are ignored, with no state change.

## Timing
- Reset, synchronous: on the first rising edge with reset high, count = 0, pointers = 0, proto_err = 0. While reset is high, send_ready = 0 and recv_valid = 0 combinationally. Storage contents are not reset.
- Reset taken mid-operation discards all entries; the queue is empty in the cycle after reset deasserts.
- Latency: an entry pushed in cycle N has recv_valid high in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained.
- Full: after the push that makes count == DEPTH, send_ready is low from the next cycle. It returns high the cycle after any pop.
- Empty: after the pop that makes count == 0, recv_valid is low from the next cycle.
- count, almost_full and proto_err are registered or derived from registered state only; they carry no combinational path from inputs.
- send_ready and recv_valid depend only on count and reset, never on same-cycle send_valid or recv_ready.

## Structure
- Shared package store_fetch_pkg holds:
  - the StoreToFetchPacket typedef;
  - STF_QUEUE_DEPTH_DEFAULT (4);
  - the store_to_fetch_count_t width helper.
- The single-slot bus's init/send/recv helper functions are superseded by this handshake and are not carried over.
- Sub-module stf_queue_storage: DEPTH × DATA_WIDTH register file with one write port and one asynchronous read port, with no reset. All control stays in the top module.

## Test plan
- Reset, then 3 pushes (0xA1, 0xA2, 0xA3) with recv_ready = 0 → count = 3, almost_full = 1 (DEPTH = 4); drain → 0xA1, 0xA2, 0xA3 in order, count back to 0.
- Fill to 4 entries, hold send_valid with STRICT = 1 → send_ready = 0, proto_err = 1 the next cycle and stays set; contents are unchanged.
- Sustained push and pop every cycle for 20 cycles with 0x00..0x13 → output sequence identical, count steady at 1, pointers wrap 5 times.
- Count = 2, flush asserted together with a push of 0x55 → next cycle count = 0, recv_valid = 0, 0x55 is never delivered.
- Reset asserted with count = 3 → send_ready = 0 and recv_valid = 0 during reset; after release count = 0 and the next push of 0x77 is popped first.
- STRICT = 0, send_valid held while full → no proto_err; the entry is accepted the cycle after the first pop.
